m_unit_param: RTL
=================

// Module: m_unit_param
// PURPOSE
// Parametrised RV32M/RV64M co-processor on the PCPI port. Decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Uses a pipelined multiplier and a radix-2^DIV_BITS iterative divider with fast paths and an abort input.
// An optional quotient/remainder cache returns the REM that follows a DIV (or the reverse) in one cycle.
// PARAMETERS
// XLEN         32  operand/result width (32 or 64)
// DIV_BITS     1   quotient bits per divide cycle (1,2,4; must divide XLEN)
// MUL_STAGES   1   extra register stages after the multiplier (0..3)
// EN_DIV_CACHE 1   1 = keep last division operands and results for reuse
// PORTS
// clk          in   1     clock
// resetn       in   1     reset, asynchronous, active-high
// pcpi_valid   in   1     instruction offered; held high by the core until pcpi_ready
// pcpi_insn    in   32    instruction word
// pcpi_rs1     in   XLEN  operand A
// pcpi_rs2     in   XLEN  operand B
// pcpi_abort   in   1     kill the current operation (pipeline flush)
// pcpi_busy    out  1     operation in progress
// pcpi_ready   out  1     one-cycle pulse; result valid this cycle
// pcpi_wr      out  1     write-back strobe, equal to pcpi_ready
// pcpi_rd      out  XLEN  result; 0 whenever pcpi_ready=0
// BEHAVIOUR
// Reset: state=IDLE, all outputs 0, cache invalid, internal operand/result registers 0.
// Accept: in IDLE when pcpi_valid, opcode=0110011, funct7=0000001 and !pcpi_abort. Call this cycle T.
//   At T the block latches funct3, rs1, rs2, sign flags and magnitudes. Operands are never re-read after T.
// States: IDLE, MUL, DIV, DONE.
//   pcpi_busy=1 in MUL and DIV, 0 in IDLE and DONE.
//   pcpi_ready=pcpi_wr=1 only in DONE. DONE always goes to IDLE next cycle.
//   The next accept is possible at DONE+1, so there is one idle bubble between operations.
// MUL: (XLEN+1)x(XLEN+1) signed product of operands extended per funct3.
//   MULH: both operands signed. MULHSU: rs1 signed. MUL/MULHU: unsigned.
//   State MUL lasts MUL_STAGES+1 cycles (T+1..T+1+MUL_STAGES); DONE at T+MUL_STAGES+2.
//   MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
// DIV/REM: unsigned restoring division on magnitudes. DIV and REM take signed magnitudes; DIVU and REMU use raw values.
//   N=XLEN/DIV_BITS iterations; state DIV covers T+1..T+N; DONE at T+N+1.
//   Sign fix in DONE: negate the quotient if sign(rs1)!=sign(rs2) for DIV; negate the remainder if rs1<0 for REM.
// Fast paths, decided at T, go straight to DONE at T+1:
//   rs2==0: quotient = all ones (DIV and DIVU); remainder = rs1.
//   signed overflow (rs1=MIN_INT, rs2=-1, DIV/REM): quotient = MIN_INT, remainder = 0.
//   |rs1|<|rs2| (magnitudes for signed ops): quotient = 0, remainder = rs1 unchanged.
//   cache hit: EN_DIV_CACHE=1, cache valid, same signedness (DIV/REM vs DIVU/REMU), and rs1 and rs2 equal to the cached operands.
//     A hit returns the cached signed-fixed quotient or remainder.
// Cache: written in DONE by every division-class op, fast paths included.
//   Invalidated on reset and on abort of a division.
//   Overwritten by any new division; MUL ops leave it untouched.
// Abort: pcpi_abort=1 in MUL, DIV or DONE forces IDLE next cycle.
//   When aborted, the block emits no ready pulse for that op and pcpi_rd stays 0.
//   In DONE, abort and ready in the same cycle: ready still pulses and the core discards it.
//   Abort together with valid in IDLE: nothing is accepted.
// Reset mid-operation: immediate return to IDLE; no ready pulse.
// Non-matching instructions are ignored: no busy, no ready.
// TESTING
// MUL 7 x 0xFFFFFFFD (-3) -> 0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; ready exactly at T+MUL_STAGES+2.
// DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. With DIV_BITS=2, XLEN=32: ready at T+17. Sweep DIV_BITS 1/2/4.
// DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; DIVU 3/10 -> 0. All with ready at T+1.
// DIV 100/7 -> 14, then REM 100/7 -> 2 at T+1 (cache hit); then REMU 100/7 -> full latency (signedness mismatch).
// Abort at T+5 of a DIV: no ready, busy drops at T+6; next DIV 100/7 takes full latency (cache invalid).
// Reset asserted mid-MUL -> outputs 0 asynchronously; back-to-back valid after DONE accepted at DONE+1.

Source files
------------

// File: rtl/m_unit_param.sv
// RV32M/RV64M co-processor on the PCPI port: a pipelined multiplier, a radix-2^DIV_BITS
// restoring divider with fast paths, and a one-entry quotient/remainder cache.
module m_unit_param #(
  parameter int XLEN         = 32,
  parameter int DIV_BITS     = 1,
  parameter int MUL_STAGES   = 1,
  parameter int EN_DIV_CACHE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  input  logic            pcpi_abort,
  output logic            pcpi_busy,
  output logic            pcpi_ready,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd
);

  localparam int N  = XLEN / DIV_BITS;
  localparam int CW = 8;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_rs1, r_rs2, r_dvs, r_quo, r_rem;
  logic            r_a_sgn, r_b_sgn, r_neg_q, r_neg_r;
  logic [CW-1:0]   r_cnt;

  logic            r_c_valid, r_c_sgn;
  logic [XLEN-1:0] r_c_rs1, r_c_rs2, r_c_quo, r_c_rem;

  // ---------------- decode and fast-path detection (cycle T) ----------------
  logic            w_match, w_accept, w_div_sgn, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic            w_b_zero, w_ovf, w_small, w_hit, w_fast;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_insn_unused;

  assign w_match   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
  assign w_accept  = (r_state == S_IDLE) && pcpi_valid && w_match && !pcpi_abort;
  assign w_f3      = pcpi_insn[14:12];
  assign w_div_sgn = w_f3[2] & ~w_f3[0];
  assign w_a_sgn   = w_f3[2] ? ~w_f3[0] : (w_f3 == 3'b001 || w_f3 == 3'b010);
  assign w_b_sgn   = w_f3[2] ? ~w_f3[0] : (w_f3 == 3'b001);
  assign w_a_neg   = w_a_sgn & pcpi_rs1[XLEN-1];
  assign w_b_neg   = w_b_sgn & pcpi_rs2[XLEN-1];
  assign w_a_mag   = w_a_neg ? -pcpi_rs1 : pcpi_rs1;
  assign w_b_mag   = w_b_neg ? -pcpi_rs2 : pcpi_rs2;
  assign w_b_zero  = (pcpi_rs2 == '0);
  assign w_ovf     = w_div_sgn && (pcpi_rs1 == MIN_INT) && (pcpi_rs2 == '1);
  assign w_small   = (w_a_mag < w_b_mag);
  assign w_hit     = (EN_DIV_CACHE != 0) && r_c_valid && (r_c_sgn == w_div_sgn) &&
                     (r_c_rs1 == pcpi_rs1) && (r_c_rs2 == pcpi_rs2);
  assign w_fast    = w_b_zero || w_ovf || w_small || w_hit;
  assign w_insn_unused = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (!w_f3[2])    w_state_nxt = S_MUL;
        else if (w_fast) w_state_nxt = S_DONE;
        else             w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (pcpi_abort)        w_state_nxt = S_IDLE;
        else if (r_cnt == '0)  w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- multiplier ----------------
  logic signed [XLEN:0]     w_mul_a, w_mul_b;
  logic signed [2*XLEN+1:0] w_prod;
  logic [2*XLEN-1:0]        r_mul_pipe [MUL_STAGES+1];
  logic                     w_prod_unused;

  assign w_mul_a       = {r_a_sgn & r_rs1[XLEN-1], r_rs1};
  assign w_mul_b       = {r_b_sgn & r_rs2[XLEN-1], r_rs2};
  assign w_prod        = w_mul_a * w_mul_b;
  assign w_prod_unused = ^w_prod[2*XLEN+1:2*XLEN];

  // NOTE: the product pipeline is an ordinary register chain, so it is reset like any other state.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int k = 0; k <= MUL_STAGES; k++) r_mul_pipe[k] <= '0;
    end else begin
      r_mul_pipe[0] <= w_prod[2*XLEN-1:0];
      for (int k = 1; k <= MUL_STAGES; k++) r_mul_pipe[k] <= r_mul_pipe[k-1];
    end
  end

  // ---------------- divider step: DIV_BITS restoring iterations per cycle ----------------
  logic [XLEN-1:0] w_quo_nxt, w_rem_nxt, w_quo_fix, w_rem_fix;
  logic [XLEN:0]   w_trial;

  always_comb begin
    w_quo_nxt = r_quo;
    w_rem_nxt = r_rem;
    w_trial   = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      w_trial   = {w_rem_nxt, w_quo_nxt[XLEN-1]};
      w_quo_nxt = {w_quo_nxt[XLEN-2:0], 1'b0};
      if (w_trial >= {1'b0, r_dvs}) begin
        w_trial      = w_trial - {1'b0, r_dvs};
        w_quo_nxt[0] = 1'b1;
      end
      w_rem_nxt = w_trial[XLEN-1:0];
    end
  end

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  // ---------------- operand latch and divider datapath ----------------
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_f3 <= '0; r_rs1 <= '0; r_rs2 <= '0; r_dvs <= '0; r_quo <= '0; r_rem <= '0;
      r_a_sgn <= 1'b0; r_b_sgn <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_cnt <= '0;
    end else if (w_accept) begin
      r_f3    <= w_f3;
      r_rs1   <= pcpi_rs1;
      r_rs2   <= pcpi_rs2;
      r_a_sgn <= w_a_sgn;
      r_b_sgn <= w_b_sgn;
      r_dvs   <= w_b_mag;
      r_cnt   <= w_f3[2] ? CW'(N-1) : CW'(MUL_STAGES);
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      // Fast paths load final, already sign-fixed values so DONE needs no correction.
      if (w_b_zero) begin
        r_quo <= '1;       r_rem <= pcpi_rs1;
      end else if (w_ovf) begin
        r_quo <= MIN_INT;  r_rem <= '0;
      end else if (w_hit) begin
        r_quo <= r_c_quo;  r_rem <= r_c_rem;
      end else if (w_small) begin
        r_quo <= '0;       r_rem <= pcpi_rs1;
      end else begin
        r_quo   <= w_a_mag;
        r_rem   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else begin
      if (r_state == S_DIV) begin
        r_quo <= w_quo_nxt;
        r_rem <= w_rem_nxt;
      end
      if ((r_state == S_DIV || r_state == S_MUL) && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // ---------------- division cache ----------------
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_c_valid <= 1'b0; r_c_sgn <= 1'b0;
      r_c_rs1 <= '0; r_c_rs2 <= '0; r_c_quo <= '0; r_c_rem <= '0;
    end else if (r_state == S_DONE && r_f3[2]) begin
      r_c_valid <= 1'b1;
      r_c_sgn   <= ~r_f3[0];
      r_c_rs1   <= r_rs1;
      r_c_rs2   <= r_rs2;
      r_c_quo   <= w_quo_fix;
      r_c_rem   <= w_rem_fix;
    end else if (r_state == S_DIV && pcpi_abort) begin
      r_c_valid <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  logic [XLEN-1:0] w_result;

  always_comb begin
    w_result   = '0;
    pcpi_busy  = (r_state == S_MUL) || (r_state == S_DIV);
    pcpi_ready = (r_state == S_DONE);
    pcpi_wr    = (r_state == S_DONE);
    case (r_f3)
      3'b000:                 w_result = r_mul_pipe[MUL_STAGES][XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = r_mul_pipe[MUL_STAGES][2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_result = w_quo_fix;
      default:                w_result = w_rem_fix;
    endcase
    pcpi_rd = pcpi_ready ? w_result : '0;
  end

endmodule
